// File: rtl/branch_pkg.sv
// Shared definitions for the gshare pattern history table.
//   - 2-bit saturating counter width and encodings
//   - INIT_VALUE written into every entry by the post-reset sweep
//   - INIT/READY state enum for the table controller
package branch_pkg;

    localparam int CTR_WIDTH = 2;

    localparam logic [CTR_WIDTH-1:0] CTR_STRONG_NT = 2'b00;
    localparam logic [CTR_WIDTH-1:0] CTR_WEAK_NT   = 2'b01;
    localparam logic [CTR_WIDTH-1:0] CTR_WEAK_T    = 2'b10;
    localparam logic [CTR_WIDTH-1:0] CTR_STRONG_T  = 2'b11;

    // LUT memory has no reset, so every entry is swept to weakly not-taken.
    localparam logic [CTR_WIDTH-1:0] INIT_VALUE = CTR_WEAK_NT;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } pht_state_e;

endpackage

// File: rtl/double_port_memory.sv
// Distributed (LUT) memory with one synchronous write port and two
// asynchronous read ports. Contents are not reset.
// Ports:
//   clk                 write clock
//   wt_en/wt_addr/wt_data   write port, committed on the rising edge
//   rd1_addr/rd1_data   combinational read port 1
//   rd2_addr/rd2_data   combinational read port 2
module double_port_memory #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  wt_en,
    input  logic [ADDR_WIDTH-1:0] wt_addr,
    input  logic [DATA_WIDTH-1:0] wt_data,
    input  logic [ADDR_WIDTH-1:0] rd1_addr,
    output logic [DATA_WIDTH-1:0] rd1_data,
    input  logic [ADDR_WIDTH-1:0] rd2_addr,
    output logic [DATA_WIDTH-1:0] rd2_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Storage write; deliberately no reset so it maps onto LUT RAM.
    always_ff @(posedge clk) begin
        if (wt_en) begin
            mem_q[wt_addr] <= wt_data;
        end
    end

    assign rd1_data = mem_q[rd1_addr];
    assign rd2_data = mem_q[rd2_addr];

endmodule

// File: rtl/branch_pht.sv
// Gshare pattern history table. Predicts branch direction in the same cycle
// from a 2-bit counter indexed by PC xor global history, and trains counters
// from resolved branches through a one-stage read-modify-write pipeline with
// forwarding. After reset the table is swept to weakly not-taken before
// predictions are declared valid.
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   pred_valid, pred_pc       fetch request (pred_valid shifts the history)
//   pred_ready                table initialised
//   pred_taken                predicted direction
//   pred_index, pred_ghr      index and history to carry down the pipe
//   upd_valid, upd_index, upd_ghr, upd_taken, upd_mispredict
//                             resolved-branch training / history recovery
module branch_pht
    import branch_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int GHR_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  pred_valid,
    input  logic [31:0]           pred_pc,
    output logic                  pred_ready,
    output logic                  pred_taken,
    output logic [ADDR_WIDTH-1:0] pred_index,
    output logic [GHR_WIDTH-1:0]  pred_ghr,
    input  logic                  upd_valid,
    input  logic [ADDR_WIDTH-1:0] upd_index,
    input  logic [GHR_WIDTH-1:0]  upd_ghr,
    input  logic                  upd_taken,
    input  logic                  upd_mispredict
);

    localparam logic [ADDR_WIDTH-1:0] SWEEP_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] SWEEP_LAST = {ADDR_WIDTH{1'b1}};

    // Saturating 2-bit counter update.
    function automatic logic [CTR_WIDTH-1:0] ctr_next(
        input logic [CTR_WIDTH-1:0] ctr,
        input logic                 taken
    );
        logic [CTR_WIDTH-1:0] res;
        if (taken) begin
            if (ctr == CTR_STRONG_T) begin
                res = ctr;
            end else begin
                res = ctr + 2'b01;
            end
        end else begin
            if (ctr == CTR_STRONG_NT) begin
                res = ctr;
            end else begin
                res = ctr - 2'b01;
            end
        end
        return res;
    endfunction

    pht_state_e               state_q, state_d;
    logic [ADDR_WIDTH-1:0]    sweep_q, sweep_d;
    logic [GHR_WIDTH-1:0]     ghr_q, ghr_d;
    logic                     wr_valid_q, wr_valid_d;
    logic [ADDR_WIDTH-1:0]    wr_index_q, wr_index_d;
    logic [CTR_WIDTH-1:0]     wr_data_q, wr_data_d;

    logic                     ready_s;
    logic                     upd_fire_s;
    logic [ADDR_WIDTH-1:0]    ghr_ext_s;
    logic [ADDR_WIDTH-1:0]    pred_index_s;
    logic [CTR_WIDTH-1:0]     mem_rd1_s, mem_rd2_s;
    logic [CTR_WIDTH-1:0]     rd1_data_s, rd2_data_s;
    logic                     pred_taken_s;
    logic                     mem_we_s;
    logic [ADDR_WIDTH-1:0]    mem_waddr_s;
    logic [CTR_WIDTH-1:0]     mem_wdata_s;
    logic                     unused_bits_s;

    // Only the word-aligned index bits of the PC and the low history bits of
    // upd_ghr are meaningful here.
    assign unused_bits_s = ^{pred_pc[31:ADDR_WIDTH+2], pred_pc[1:0], upd_ghr[GHR_WIDTH-1]};

    assign ready_s    = (state_q == READY);
    assign upd_fire_s = ready_s & upd_valid;

    // Zero-extend the history to index width (GHR_WIDTH may equal ADDR_WIDTH).
    always_comb begin
        ghr_ext_s                = '0;
        ghr_ext_s[GHR_WIDTH-1:0] = ghr_q;
    end

    assign pred_index_s = pred_pc[ADDR_WIDTH+1:2] ^ ghr_ext_s;

    // Forward the pending write so reads never see a stale counter.
    always_comb begin
        rd1_data_s = mem_rd1_s;
        rd2_data_s = mem_rd2_s;
        if (wr_valid_q && (wr_index_q == pred_index_s)) begin
            rd1_data_s = wr_data_q;
        end else begin
            rd1_data_s = mem_rd1_s;
        end
        if (wr_valid_q && (wr_index_q == upd_index)) begin
            rd2_data_s = wr_data_q;
        end else begin
            rd2_data_s = mem_rd2_s;
        end
    end

    assign pred_taken_s = ready_s & rd1_data_s[CTR_WIDTH-1];

    // Controller: sweep every entry once, then stay in READY until reset.
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        case (state_q)
            INIT: begin
                sweep_d = sweep_q + SWEEP_ONE;
                if (sweep_q == SWEEP_LAST) begin
                    state_d = READY;
                end else begin
                    state_d = INIT;
                end
            end
            READY: begin
                state_d = READY;
                sweep_d = sweep_q;
            end
            default: begin
                state_d = INIT;
                sweep_d = '0;
            end
        endcase
    end

    // Global history: recovery wins over the speculative shift.
    always_comb begin
        ghr_d = ghr_q;
        if (upd_fire_s && upd_mispredict) begin
            ghr_d = {upd_ghr[GHR_WIDTH-2:0], upd_taken};
        end else if (ready_s && pred_valid) begin
            ghr_d = {ghr_q[GHR_WIDTH-2:0], pred_taken_s};
        end else begin
            ghr_d = ghr_q;
        end
    end

    // Update stage 0: read-modify into the write stage.
    always_comb begin
        wr_valid_d = 1'b0;
        wr_index_d = wr_index_q;
        wr_data_d  = wr_data_q;
        if (upd_fire_s) begin
            wr_valid_d = 1'b1;
            wr_index_d = upd_index;
            wr_data_d  = ctr_next(rd2_data_s, upd_taken);
        end else begin
            wr_valid_d = 1'b0;
        end
    end

    // Memory write port: sweep during INIT, write stage once READY.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = '0;
        mem_wdata_s = INIT_VALUE;
        if (ready_s) begin
            mem_we_s    = wr_valid_q;
            mem_waddr_s = wr_index_q;
            mem_wdata_s = wr_data_q;
        end else begin
            mem_we_s    = 1'b1;
            mem_waddr_s = sweep_q;
            mem_wdata_s = INIT_VALUE;
        end
    end

    // State, history and write-stage registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= INIT;
            sweep_q    <= '0;
            ghr_q      <= '0;
            wr_valid_q <= 1'b0;
            wr_index_q <= '0;
            wr_data_q  <= INIT_VALUE;
        end else begin
            state_q    <= state_d;
            sweep_q    <= sweep_d;
            ghr_q      <= ghr_d;
            wr_valid_q <= wr_valid_d;
            wr_index_q <= wr_index_d;
            wr_data_q  <= wr_data_d;
        end
    end

    double_port_memory #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (CTR_WIDTH)
    ) u_mem (
        .clk      (clk),
        .wt_en    (mem_we_s),
        .wt_addr  (mem_waddr_s),
        .wt_data  (mem_wdata_s),
        .rd1_addr (pred_index_s),
        .rd1_data (mem_rd1_s),
        .rd2_addr (upd_index),
        .rd2_data (mem_rd2_s)
    );

    assign pred_ready = ready_s;
    assign pred_taken = pred_taken_s;
    assign pred_index = pred_index_s;
    assign pred_ghr   = ghr_q;

endmodule

// File: tb/tb_branch_pht.sv
// Self-checking bench for branch_pht with a 16-entry table and 4-bit history.
// A reference model keeps the architectural counter values and history as
// plain integers; an update becomes visible to the very next cycle.
module tb_branch_pht;

    logic        clk;
    logic        rstn;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        pred_ready;
    logic        pred_taken;
    logic [3:0]  pred_index;
    logic [3:0]  pred_ghr;
    logic        upd_valid;
    logic [3:0]  upd_index;
    logic [3:0]  upd_ghr;
    logic        upd_taken;
    logic        upd_mispredict;

    branch_pht #(
        .ADDR_WIDTH (4),
        .GHR_WIDTH  (4)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .pred_valid     (pred_valid),
        .pred_pc        (pred_pc),
        .pred_ready     (pred_ready),
        .pred_taken     (pred_taken),
        .pred_index     (pred_index),
        .pred_ghr       (pred_ghr),
        .upd_valid      (upd_valid),
        .upd_index      (upd_index),
        .upd_ghr        (upd_ghr),
        .upd_taken      (upd_taken),
        .upd_mispredict (upd_mispredict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    int mctr [16];
    int mghr;
    int mcnt;
    bit mready;

    typedef struct {
        logic        pv;
        logic [31:0] pc;
        logic        uv;
        logic [3:0]  ui;
        logic [3:0]  ug;
        logic        ut;
        logic        um;
        logic        exp_taken;
        logic [3:0]  exp_ghr;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int sat(input int c, input logic t);
        if (t) return (c >= 3) ? 3 : c + 1;
        else   return (c <= 0) ? 0 : c - 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mctr[i] = 1;
        mghr   = 0;
        mcnt   = 0;
        mready = 1'b0;
    endtask

    // One clock cycle: compare outputs to the model, then advance the model.
    task automatic tick();
        int idx;
        bit et;
        #1;
        idx = int'(pred_pc[5:2]) ^ mghr;
        et  = mready && (mctr[idx] >= 2);
        check("ready",  {31'd0, pred_ready}, {31'd0, mready});
        check("index",  {28'd0, pred_index}, idx);
        check("ghr",    {28'd0, pred_ghr},   mghr);
        check("taken",  {31'd0, pred_taken}, {31'd0, et});
        @(posedge clk);
        if (rstn) begin
            if (mready) begin
                if (upd_valid) mctr[upd_index] = sat(mctr[upd_index], upd_taken);
                if (upd_valid && upd_mispredict)
                    mghr = ((int'(upd_ghr) << 1) | int'(upd_taken)) & 15;
                else if (pred_valid)
                    mghr = ((mghr << 1) | int'(et)) & 15;
            end else begin
                mcnt++;
                if (mcnt >= 16) mready = 1'b1;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        pred_valid     = 1'b0;
        upd_valid      = 1'b0;
        upd_index      = 4'd0;
        upd_ghr        = 4'd0;
        upd_taken      = 1'b0;
        upd_mispredict = 1'b0;
    endtask

    initial begin
        //            pv    pc        uv    ui     ug      ut    um    taken ghr
        vecs[0]  = '{1'b0, 32'h20, 1'b1, 4'd8, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0};
        vecs[1]  = '{1'b0, 32'h20, 1'b1, 4'd8, 4'h0, 1'b1, 1'b0, 1'b1, 4'h0};
        vecs[2]  = '{1'b0, 32'h20, 1'b1, 4'd8, 4'h0, 1'b1, 1'b0, 1'b1, 4'h0};
        vecs[3]  = '{1'b0, 32'h20, 1'b0, 4'd0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h0};
        vecs[4]  = '{1'b0, 32'h0C, 1'b1, 4'd3, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0};
        vecs[5]  = '{1'b0, 32'h0C, 1'b1, 4'd3, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0};
        vecs[6]  = '{1'b0, 32'h0C, 1'b1, 4'd3, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0};
        vecs[7]  = '{1'b0, 32'h0C, 1'b1, 4'd3, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0};
        vecs[8]  = '{1'b0, 32'h0C, 1'b1, 4'd3, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0};
        vecs[9]  = '{1'b0, 32'h0C, 1'b0, 4'd0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0};
        vecs[10] = '{1'b0, 32'h14, 1'b1, 4'd5, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0};
        vecs[11] = '{1'b0, 32'h14, 1'b0, 4'd0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h0};
        vecs[12] = '{1'b0, 32'h14, 1'b0, 4'd0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h0};
        vecs[13] = '{1'b0, 32'h00, 1'b1, 4'd0, 4'h2, 1'b1, 1'b1, 1'b0, 4'h0};
        vecs[14] = '{1'b1, 32'h34, 1'b0, 4'd0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h5};
        vecs[15] = '{1'b0, 32'h00, 1'b1, 4'd0, 4'h2, 1'b1, 1'b1, 1'b0, 4'hB};
        vecs[16] = '{1'b1, 32'h34, 1'b1, 4'd3, 4'h2, 1'b0, 1'b1, 1'b1, 4'h5};
        vecs[17] = '{1'b0, 32'h00, 1'b0, 4'd0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h4};

        idle_inputs();
        rstn    = 1'b0;
        pred_pc = 32'h20;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        check("rst_ready",    {31'd0, pred_ready}, 32'd0);
        check("rst_taken",    {31'd0, pred_taken}, 32'd0);
        check("rst_ghr",      {28'd0, pred_ghr},   32'd0);
        check("rst_index",    {28'd0, pred_index}, 32'd8);
        check("rst_wr_valid", {31'd0, dut.wr_valid_q}, 32'd0);
        rstn = 1'b1;

        // Sweep: not ready for cycles 0..15, ready at cycle 16.
        for (int k = 0; k < 16; k++) tick();
        #1;
        check("ready_at_16", {31'd0, pred_ready}, 32'd1);

        // Every entry starts weakly not-taken.
        for (int i = 0; i < 16; i++) begin
            pred_pc = i << 2;
            #1;
            check("init_entry_nt", {31'd0, pred_taken}, 32'd0);
            tick();
        end

        // Directed vectors: forwarding, saturation, history shift/recovery.
        for (int r = 0; r < 18; r++) begin
            pred_valid     = vecs[r].pv;
            pred_pc        = vecs[r].pc;
            upd_valid      = vecs[r].uv;
            upd_index      = vecs[r].ui;
            upd_ghr        = vecs[r].ug;
            upd_taken      = vecs[r].ut;
            upd_mispredict = vecs[r].um;
            #1;
            check($sformatf("vec%0d_taken", r), {31'd0, pred_taken}, {31'd0, vecs[r].exp_taken});
            check($sformatf("vec%0d_ghr", r),   {28'd0, pred_ghr},   {28'd0, vecs[r].exp_ghr});
            tick();
        end

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++) begin
            pred_valid     = 1'($urandom_range(0, 1));
            pred_pc        = $urandom;
            upd_valid      = 1'($urandom_range(0, 1));
            upd_index      = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            upd_ghr        = 4'($urandom_range(0, 15));
            upd_taken      = 1'($urandom_range(0, 1));
            upd_mispredict = ($urandom_range(0, 3) == 0);
            tick();
        end

        // Reset while an update is pending in the write stage.
        idle_inputs();
        pred_valid = 1'b1;
        upd_valid  = 1'b1;
        upd_index  = 4'd5;
        upd_taken  = 1'b1;
        tick();
        rstn = 1'b0;
        model_reset();
        #1;
        check("midrst_wr_valid", {31'd0, dut.wr_valid_q}, 32'd0);
        check("midrst_ghr",      {28'd0, pred_ghr},       32'd0);
        check("midrst_ready",    {31'd0, pred_ready},     32'd0);
        idle_inputs();
        tick();
        tick();
        rstn = 1'b1;
        for (int k = 0; k < 16; k++) tick();
        #1;
        check("ready_after_rst", {31'd0, pred_ready}, 32'd1);

        // Each entry must be back at 01: one taken update flips it to taken.
        for (int i = 0; i < 16; i++) begin
            pred_pc   = i << 2;
            upd_valid = 1'b1;
            upd_index = 4'(i);
            upd_taken = 1'b1;
            #1;
            check("post_rst_nt", {31'd0, pred_taken}, 32'd0);
            tick();
            upd_valid = 1'b0;
            #1;
            check("post_rst_one_step", {31'd0, pred_taken}, 32'd1);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_pht.md
# branch_pht

Gshare pattern history table for the branch unit: 2-bit saturating counters held in distributed LUT memory, indexed by PC xor global history. Gives a same-cycle taken/not-taken prediction to fetch, and accepts resolved-branch updates from the execute stage through a one-stage read-modify-write pipeline with forwarding. Clears its table with a sweep after reset, because LUT memory has no reset.

## Interface
- ADDR_WIDTH, 8, log2 of table entries.
- GHR_WIDTH, 8, global history length; must be ≤ ADDR_WIDTH.
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  reset: asynchronous, active-low.
- pred_valid  in  1  fetch presents a branch PC for prediction this cycle.
- pred_pc  in  32  PC of the branch being predicted.
- pred_ready  out  1  table initialised; predictions are valid.
- pred_taken  out  1  predicted direction (counter MSB).
- pred_index  out  ADDR_WIDTH  table index used; carried down the pipe for the later update.
- pred_ghr  out  GHR_WIDTH  history at prediction time; carried down the pipe for recovery.
- upd_valid  in  1  a resolved branch is being reported.
- upd_index  in  ADDR_WIDTH  index captured at prediction time.
- upd_ghr  in  GHR_WIDTH  history captured at prediction time.
- upd_taken  in  1  actual direction.
- upd_mispredict  in  1  predicted direction was wrong.

## Operation
- Counter encoding: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.
  - Taken increments the counter, saturating at 11.
  - Not-taken decrements it, saturating at 00.
- Index = pred_pc[ADDR_WIDTH+1:2] xor zero-extended ghr.
- FSM states: INIT, READY.
  - Reset enters INIT with sweep counter 0.
  - INIT writes 01 to the entry at the sweep counter every cycle and increments the counter.
  - When the entry 2^ADDR_WIDTH−1 is written, the FSM moves to READY. READY is held until the next reset.
- In INIT: pred_ready=0, pred_taken=0, and upd_valid is ignored. pred_index and pred_ghr stay combinational.
- Prediction (READY), combinational via read port 1:
  - pred_taken = MSB of the entry at the index, taking forwarded data if there is a match (below).
  - If pred_valid, the history shifts speculatively on the clock edge: ghr ← {ghr[GHR_WIDTH−2:0], pred_taken}.
- Update stage 0 (READY and upd_valid):
  - Read the counter at upd_index via read port 2.
  - Compute the saturated next value.
  - Register it into the write stage: wr_valid, wr_index, wr_data.
- Update stage 1: the write stage drives the memory write port with wt_en = wr_valid.
- Forwarding: when wr_valid and wr_index equals the port-1 or port-2 read index, use wr_data in place of the memory data. This covers back-to-back updates to the same entry and a prediction that reads a pending entry.
- Recovery: upd_valid && upd_mispredict sets ghr ← {upd_ghr[GHR_WIDTH−2:0], upd_taken}.
  - Recovery takes priority over a speculative shift in the same cycle; that cycle's prediction does not shift the history.
- Updates with upd_mispredict=0 still train the counter and leave ghr untouched.
- Memory write port mux: the INIT sweep in INIT, the write stage in READY.

## Timing
- Reset values: state INIT, sweep counter 0, ghr 0, wr_valid 0, pred_ready 0.
- Prediction latency: 0 cycles (same cycle as pred_pc).
- Init: after rstn rises, the sweep writes entries in cycles 0..N−1 (N = 2^ADDR_WIDTH). pred_ready=1 from cycle N.
- Update in cycle t:
  - Counter committed to memory at the end of cycle t+1.
  - Data forwarded during cycle t+1.
  - Memory read direct from cycle t+2.
- One update accepted per cycle, with no backpressure.
- rstn asserted at any time: immediate return to INIT, pending write dropped, ghr cleared, full sweep repeated.

## Structure
- Shared package branch_pkg holds:
  - Counter encodings and the INIT_VALUE (2'b01).
  - The INIT/READY state enum.
  - Counter width (2).
- Sub-module: one double_port_memory instance (ADDR_WIDTH, DATA_WIDTH=2).
  - Read port 1 serves prediction.
  - Read port 2 serves update.
  - The write port is muxed between the sweep and the write stage.
- Saturating next-value logic is a local function; no further sub-modules.

## Test plan
Benches run with ADDR_WIDTH=4, GHR_WIDTH=4.
- Reset then idle → pred_ready=0 for cycles 0..15 and 1 at cycle 16; every index predicts not-taken (counter 01).
- ghr=0, pred_pc=0x20 (index 8); updates to index 8 with taken=1 in two consecutive cycles → counter 01→10→11 via forwarding, pred_taken=1 at cycle t+1; a third taken update keeps 11.
- Four not-taken updates to index 3 → counter saturates at 00; then one taken → 01; pred_taken stays 0 throughout.
- pred_valid with pred_taken=1 at ghr=0101 → ghr=1011 next cycle; same-cycle upd_mispredict with upd_ghr=0010, upd_taken=0 → ghr=0100 instead.
- Update index 5 to taken in cycle t, pred_pc mapping to index 5 in cycle t+1 → pred_taken=1 from forwarded data.
- rstn pulsed low mid-update after entries were trained → wr_valid cleared, ghr=0, pred_ready low for 16 cycles, all entries read 01 afterwards.
